// File: rtl/light_nn_pkg.sv
// light_nn_pkg: shared FSM states and default widths for the weight streaming path
package light_nn_pkg;
    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;
    localparam int ROM_LATENCY = 1;
    localparam int DEF_ADDR_WIDTH = 12;
    localparam int DEF_DATA_WIDTH = 8;
endpackage

// File: rtl/weight_skid_fifo.sv
// weight_skid_fifo: 2-entry fall-through FIFO; an empty FIFO presents din directly so a landing word can leave the same cycle
module weight_skid_fifo #(
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic [1:0]       count
);
    logic [WIDTH-1:0] mem0, mem1;
    logic deq, wr;
    logic [1:0] keep;
    assign deq  = pop && count != 2'd0;
    assign wr   = push && !(pop && count == 2'd0);
    assign keep = count - 2'(deq);
    assign dout = count == 2'd0 ? din : mem0;
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            count <= 2'd0;
            mem0  <= '0;
            mem1  <= '0;
        end else begin
            count <= keep + 2'(wr);
            if (deq) mem0 <= mem1;
            if (wr && keep == 2'd0) mem0 <= din;
            if (wr && keep != 2'd0) mem1 <= din;
        end
    end
endmodule

// File: rtl/rom_weight_streamer.sv
// rom_weight_streamer: walks a ROM burst and streams weights over valid/ready with a 2-entry skid buffer
module rom_weight_streamer
    import light_nn_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [LEN_WIDTH-1:0]  length,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_data,
    output logic [DATA_WIDTH-1:0] w_data,
    output logic                  w_valid,
    input  logic                  w_ready,
    output logic                  w_last
);
    state_t state, state_n;
    logic [LEN_WIDTH-1:0] left, left_n;
    logic [ADDR_WIDTH-1:0] addr_n;
    logic rd_v, rd_v_n, rd_last, rd_last_n, pend, pend_last;
    logic kill, pop, room;
    logic [1:0] count, cnt_n;
    logic [DATA_WIDTH:0] dout;

    // rd_v marks rom_addr as a live read this cycle; pend marks rom_data as its landing word
    assign kill    = abort && state != IDLE;
    assign w_valid = pend || count != 2'd0;
    assign pop     = w_valid && w_ready;
    assign cnt_n   = count + 2'(pend) - 2'(pop);
    assign room    = (cnt_n + 2'(rd_v)) < 2'd2;
    assign w_data  = w_valid ? dout[DATA_WIDTH-1:0] : '0;
    assign w_last  = w_valid && dout[DATA_WIDTH];
    assign busy    = state == FETCH || state == DRAIN;
    assign done    = state == DONE;

    weight_skid_fifo #(.WIDTH(DATA_WIDTH + 1)) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .flush(kill),
        .push (pend),
        .din  ({pend_last, rom_data}),
        .pop  (pop),
        .dout (dout),
        .count(count)
    );

    always_comb begin
        state_n   = state;
        left_n    = left;
        addr_n    = rom_addr;
        rd_v_n    = 1'b0;
        rd_last_n = 1'b0;
        case (state)
            IDLE: if (start) begin
                state_n = length == '0 ? DONE : FETCH;
                if (length != '0) begin
                    addr_n    = base_addr;
                    left_n    = length - 1'b1;
                    rd_v_n    = 1'b1;
                    rd_last_n = length == LEN_WIDTH'(1);
                end
            end
            FETCH: begin
                if (left != '0 && room) begin
                    addr_n    = rom_addr + 1'b1;
                    left_n    = left - 1'b1;
                    rd_v_n    = 1'b1;
                    rd_last_n = left == LEN_WIDTH'(1);
                end
                state_n = left_n == '0 ? DRAIN : FETCH;
            end
            DRAIN: state_n = (cnt_n == 2'd0 && !rd_v) ? DONE : DRAIN;
            default: state_n = IDLE;
        endcase
        if (kill) begin
            state_n = IDLE;
            rd_v_n  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            left      <= '0;
            rom_addr  <= '0;
            rd_v      <= 1'b0;
            rd_last   <= 1'b0;
            pend      <= 1'b0;
            pend_last <= 1'b0;
        end else begin
            state     <= state_n;
            left      <= left_n;
            rom_addr  <= addr_n;
            rd_v      <= rd_v_n;
            rd_last   <= rd_last_n;
            pend      <= rd_v && !kill;
            pend_last <= rd_last;
        end
    end
endmodule

// File: tb/tb_rom_weight_streamer.sv
// tb_rom_weight_streamer: directed bench with a ROM model returning addr[7:0]
module tb_rom_weight_streamer;
    localparam int AW = 12;
    localparam int DW = 8;
    localparam int LW = 13;

    logic clk = 1'b0;
    logic rst, start, abort, w_ready;
    logic [AW-1:0] base_addr;
    logic [LW-1:0] length;
    logic busy, done, w_valid, w_last;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_data, w_data;
    int tests = 0;
    int fails = 0;
    int beats, first, dcyc;

    always #5 clk = ~clk;
    always_ff @(posedge clk) rom_data <= rom_addr[7:0];

    rom_weight_streamer dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
        .abort(abort), .busy(busy), .done(done), .rom_addr(rom_addr), .rom_data(rom_data),
        .w_data(w_data), .w_valid(w_valid), .w_ready(w_ready), .w_last(w_last)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(input logic [AW-1:0] b, input logic [LW-1:0] n);
        start = 1'b1;
        base_addr = b;
        length = n;
        tick();
        start = 1'b0;
    endtask

    // Consume a burst under a ready pattern, checking order, w_last, stability and read-ahead
    task automatic stream(input int len, input logic [AW-1:0] b, input logic [7:0] pat,
                          input int c0, output int nb, output int fv, output int dc);
        logic hold;
        logic [9:0] prev;
        logic [7:0] e;
        logic [AW-1:0] d;
        nb = 0; fv = -1; dc = -1; hold = 1'b0; prev = '0;
        for (int c = c0; c < c0 + 80; c++) begin
            w_ready = pat[c % 8];
            if (hold) chk("stable", {22'd0, w_valid, w_last, w_data}, {22'd0, prev});
            d = rom_addr - b;
            chk("ahead", 32'((int'(d) + 1 - nb) <= 2), 32'd1);
            if (w_valid && fv < 0) fv = c;
            if (w_valid && w_ready) begin
                e = b[7:0] + 8'(nb);
                chk("data", 32'(w_data), 32'(e));
                chk("last", 32'(w_last), 32'(nb == len - 1));
                nb++;
            end
            hold = w_valid && !w_ready;
            prev = {w_valid, w_last, w_data};
            if (done) begin
                dc = c;
                chk("busy_at_done", 32'(busy), 32'd0);
                break;
            end
            tick();
        end
        chk("done_seen", 32'(done), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; w_ready = 1'b0;
        base_addr = '0; length = '0;
        tick(); tick();
        chk("rst_outs", {busy, done, w_valid, w_last, 8'(w_data), 20'(rom_addr)}, 32'd0);
        rst = 1'b0;
        tick();

        cmd(12'd10, 13'd4);
        chk("basic_addr0", 32'(rom_addr), 32'd10);
        chk("basic_busy", 32'(busy), 32'd1);
        chk("basic_nvalid", 32'(w_valid), 32'd0);
        stream(4, 12'd10, 8'hFF, 1, beats, first, dcyc);
        chk("basic_beats", beats, 4);
        chk("basic_first", first, 2);
        chk("basic_done_cyc", dcyc, 6);
        tick();
        chk("basic_done_pulse", 32'(done), 32'd0);

        cmd(12'd0, 13'd6);
        stream(6, 12'd0, 8'b1010_1001, 1, beats, first, dcyc);
        chk("bp_beats", beats, 6);
        tick();

        cmd(12'hFFE, 13'd4);
        stream(4, 12'hFFE, 8'hFF, 1, beats, first, dcyc);
        chk("wrap_beats", beats, 4);
        chk("wrap_addr_end", 32'(rom_addr), 32'h001);
        tick();

        cmd(12'h123, 13'd0);
        chk("zero_done", 32'(done), 32'd1);
        chk("zero_busy", 32'(busy), 32'd0);
        chk("zero_valid", 32'(w_valid), 32'd0);
        tick();
        chk("zero_done_end", 32'(done), 32'd0);

        cmd(12'd100, 13'd5);
        w_ready = 1'b1;
        start = 1'b1; base_addr = 12'd200; length = 13'd9;
        tick();
        start = 1'b0;
        stream(5, 12'd100, 8'hFF, 2, beats, first, dcyc);
        chk("ign_beats", beats, 5);
        chk("ign_done_cyc", dcyc, 7);
        start = 1'b1; base_addr = 12'd50; length = 13'd3;
        tick();
        chk("done_start_ign", 32'(busy), 32'd0);
        tick();
        start = 1'b0;
        chk("after_done_start", 32'(busy), 32'd1);
        chk("after_done_addr", 32'(rom_addr), 32'd50);
        stream(3, 12'd50, 8'hFF, 1, beats, first, dcyc);
        chk("after_done_beats", beats, 3);
        tick();

        cmd(12'd0, 13'd8);
        w_ready = 1'b1;
        tick();
        chk("ab_d0", 32'(w_data), 32'd0);
        tick();
        chk("ab_d1", 32'(w_data), 32'd1);
        tick();
        chk("ab_d2", 32'(w_data), 32'd2);
        tick();
        w_ready = 1'b0; abort = 1'b1;
        chk("ab_pre_valid", 32'(w_valid), 32'd1);
        tick();
        abort = 1'b0;
        chk("ab_valid", 32'(w_valid), 32'd0);
        chk("ab_busy", 32'(busy), 32'd0);
        chk("ab_done", 32'(done), 32'd0);
        tick();
        chk("ab_done2", 32'(done), 32'd0);
        chk("ab_valid2", 32'(w_valid), 32'd0);
        cmd(12'd20, 13'd2);
        stream(2, 12'd20, 8'hFF, 1, beats, first, dcyc);
        chk("ab_next_beats", beats, 2);
        chk("ab_next_done_cyc", dcyc, 4);
        tick();

        cmd(12'd30, 13'd2);
        w_ready = 1'b1;
        tick();
        chk("abl_d0", 32'(w_data), 32'h1E);
        tick();
        chk("abl_last", {w_valid, w_last, 8'(w_data)}, 32'h31F);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abl_nodone", 32'(done), 32'd0);
        chk("abl_busy", 32'(busy), 32'd0);

        cmd(12'd40, 13'd6);
        w_ready = 1'b0;
        tick(); tick();
        chk("rst_mid_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid_outs", {busy, done, w_valid, w_last, 8'(w_data), 20'(rom_addr)}, 32'd0);
        cmd(12'd60, 13'd2);
        chk("rst_restart_busy", 32'(busy), 32'd1);
        chk("rst_restart_addr", 32'(rom_addr), 32'd60);
        stream(2, 12'd60, 8'hFF, 1, beats, first, dcyc);
        chk("rst_restart_beats", beats, 2);
        chk("rst_restart_first", first, 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/rom_weight_streamer.md
Name: rom_weight_streamer

Overview:
Sequencer in front of the weight ROM (rom, 1-cycle synchronous read). It accepts a burst command (base address, word count), walks the ROM address space and streams the weights to a neuron datapath over a valid/ready interface. A 2-entry buffer absorbs the ROM read latency under backpressure, so no word is lost or duplicated. Sits between the layer controller (command side) and the MAC array (stream side).

Parameters:
ADDR_WIDTH, 12, ROM address width; must match the rom instance.
DATA_WIDTH, 8, ROM word / weight width.
LEN_WIDTH, ADDR_WIDTH+1, burst length width; allows a full-ROM burst of 2^ADDR_WIDTH words.

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  reset, synchronous, active-high
start  in  1  command strobe; sampled only in IDLE
base_addr  in  ADDR_WIDTH  first ROM address of burst
length  in  LEN_WIDTH  number of words to stream
abort  in  1  cancel current burst, synchronous
busy  out  1  high from the cycle after an accepted start until done or abort
done  out  1  one-cycle pulse after the last word handshakes
rom_addr  out  ADDR_WIDTH  registered address to rom
rom_data  in  DATA_WIDTH  rom read data; valid 1 cycle after rom_addr
w_data  out  DATA_WIDTH  weight word
w_valid  out  1  w_data valid
w_ready  in  1  consumer ready
w_last  out  1  marks final word of burst, qualified by w_valid

Behaviour:
- Reset: all outputs 0; FSM in IDLE; buffer empty; counters 0. rst has priority over every other input.
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- FSM states: IDLE, FETCH, DRAIN, DONE.
  - IDLE: on start with length>0, latch base_addr and length, go to FETCH. On start with length==0, go to DONE (no beats). start in any other state is ignored.
  - FETCH: issue one ROM read per cycle while (outstanding reads + buffer occupancy) < 2. After the last issue, go to DRAIN.
  - DRAIN: wait until the buffer is empty and no read is outstanding, then go to DONE.
  - DONE: done=1 for exactly one cycle, then go to IDLE. busy is 0 in this cycle.
- Read latency: a word addressed in cycle t is written into the buffer at the end of cycle t+1.
- Pipeline latency: start is accepted at edge 0. rom_addr=base is visible in cycle 1. w_valid=1 in cycle 2 at the earliest.
- Throughput: 1 word/cycle sustained when w_ready is held high.
- Address arithmetic: rom_addr increments by 1 modulo 2^ADDR_WIDTH. Example: base 0xFFE with length 4 reads 0xFFE, 0xFFF, 0x000, 0x001.
- Handshake: a beat transfers when w_valid && w_ready.
  - Once w_valid is raised, w_data, w_valid and w_last stay stable until the transfer.
  - w_valid is never deasserted without a transfer, except on abort or rst.
- w_last is high on exactly the length-th word of the burst.
- Backpressure: with w_ready=0, at most 2 words are buffered and issuing stalls. rom_addr holds its value while stalled.
- Abort: takes effect at the next edge in any non-IDLE state. Flush the buffer, discard in-flight reads, drop w_valid, go to IDLE. No done pulse. Abort in IDLE has no effect.
- Simultaneous events:
  - Abort together with a final handshake: the word transfers, abort wins, no done pulse.
  - start is ignored in DONE; a new start is accepted the cycle after DONE.
- rst mid-burst behaves exactly like reset: no done pulse, outputs 0.

Decomposition:
- Shared package light_nn_pkg holds:
  - FSM state enum: state_t {IDLE, FETCH, DRAIN, DONE}
  - ROM_LATENCY=1 constant
  - default ADDR_WIDTH and DATA_WIDTH values
- Sub-module weight_skid_fifo: 2-entry synchronous FIFO. Ports: clk, rst, flush, push, din, pop, dout, count. The FIFO alone carries the w_last tag bit, giving DATA_WIDTH+1 bits per entry.
- All address, counter and FSM logic stays in rom_weight_streamer.

Test Plan:
- Basic burst: bench ROM model returns data = addr[7:0]. start with base=10, length=4, w_ready=1 -> w_valid in cycles 2–5 with w_data 0x0A, 0x0B, 0x0C, 0x0D; w_last only on 0x0D; done pulse in cycle 6.
- Backpressure: base=0, length=6, w_ready toggled 1,0,0,1,0,1… -> w_data sequence is exactly 0x00–0x05, no gaps or repeats; w_data is stable while w_valid && !w_ready; rom_addr stalls with at most 2 reads ahead.
- Wrap-around: base=0xFFE, length=4 -> rom_addr sequence 0xFFE, 0xFFF, 0x000, 0x001; w_data FE, FF, 00, 01.
- Zero length and ignored start: length=0 -> done pulse in cycle 1, no w_valid. A second start asserted mid-burst -> ignored; the beat count equals the first burst's length.
- Abort mid-burst: length=8, abort after the 3rd handshake -> w_valid=0 next cycle, busy=0, no done. A following burst base=20, length=2 streams 0x14, 0x15 cleanly.
- Reset mid-burst: rst asserted for 1 cycle during FETCH -> all outputs 0 the next cycle; the FSM accepts a new start the cycle after rst deasserts.
